// File: rtl/ram_bit_serializer.sv
// Multi-channel bit serializer: loads CHANNELS parallel words, then emits one bit
// per channel per beat, walking the bit index from start_bit toward stop_bit.
module ram_bit_serializer #(
  parameter int INPUT_WIDTH = 16,
  parameter int REG_WIDTH   = 4,
  parameter int CHANNELS    = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [CHANNELS*INPUT_WIDTH-1:0] in_data,
  input  logic [REG_WIDTH-1:0]            start_bit,
  input  logic [REG_WIDTH-1:0]            stop_bit,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [CHANNELS-1:0]             out_bits,
  output logic [REG_WIDTH-1:0]            out_bit_idx,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            out_last,
  output logic                            busy
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; valid never waits on ready, and the output side holds its beat while
  // out_valid is high and out_ready is low.

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                          state;
  logic [CHANNELS*INPUT_WIDTH-1:0] data_q;
  logic [REG_WIDTH-1:0]            idx_q;
  logic [REG_WIDTH-1:0]            stop_q;
  logic                            up_q;

  logic load;
  logic beat_done;

  assign out_valid   = (state == SHIFT);
  assign busy        = (state == SHIFT);
  assign out_last    = out_valid && (idx_q == stop_q);
  assign out_bit_idx = idx_q;
  assign beat_done   = out_valid && out_ready;
  // Reopen for a new word on the final handshake so loads run back to back.
  assign in_ready    = (state == IDLE) || (beat_done && out_last);
  assign load        = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      data_q <= '0;
      idx_q  <= '0;
      stop_q <= '0;
      up_q   <= 1'b0;
    end else if (load) begin
      state  <= SHIFT;
      data_q <= in_data;
      idx_q  <= start_bit;
      stop_q <= stop_bit;
      up_q   <= (stop_bit > start_bit);
    end else if (beat_done) begin
      // idx only moves toward stop, so it cannot wrap past either end.
      if (out_last) begin
        state <= IDLE;
      end else if (up_q) begin
        idx_q <= idx_q + REG_WIDTH'(1);
      end else begin
        idx_q <= idx_q - REG_WIDTH'(1);
      end
    end
  end

  logic [INPUT_WIDTH-1:0] word;

  always_comb begin
    out_bits = '0;
    word     = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      word        = data_q[c*INPUT_WIDTH +: INPUT_WIDTH];
      out_bits[c] = word[idx_q];
    end
  end

endmodule
